// File: rtl/field_serializer_pkg.sv
// Shared types for the field serializer: field-table entry layout,
// field type encoding and protobuf wire-type constants.
package field_serializer_pkg;

  typedef enum logic [2:0] {
    FT_UINT64  = 3'd0,
    FT_INT32   = 3'd1,
    FT_FIXED32 = 3'd2,
    FT_FIXED64 = 3'd3,
    FT_NESTED  = 3'd4
  } FIELD_TYPE;

  // One field-table entry. field_id is 29 bits so the tag fits in 32 bits.
  // `nested` indexes the child table and is consumed by the object buffer.
  typedef struct packed {
    logic [28:0] field_id;
    FIELD_TYPE   field_type;
    logic [15:0] nested;
    logic [31:0] offset;
    logic [31:0] size;
  } TABLE_ENTRY;

  localparam logic [2:0] WIRE_VARINT  = 3'd0;
  localparam logic [2:0] WIRE_FIXED64 = 3'd1;
  localparam logic [2:0] WIRE_LEN     = 3'd2;
  localparam logic [2:0] WIRE_FIXED32 = 3'd5;

  function automatic logic [2:0] wire_type(input FIELD_TYPE t);
    case (t)
      FT_FIXED64: wire_type = WIRE_FIXED64;
      FT_FIXED32: wire_type = WIRE_FIXED32;
      FT_NESTED:  wire_type = WIRE_LEN;
      default:    wire_type = WIRE_VARINT;
    endcase
  endfunction

  // Tag value (field_id << 3) | wire, zero-extended to the varint width.
  function automatic logic [63:0] tag_value(input logic [28:0] fid, input FIELD_TYPE t);
    tag_value = {32'd0, fid, wire_type(t)};
  endfunction

endpackage

// File: rtl/field_serializer_varint_emitter.sv
// Emits a 64-bit value as a protobuf varint, one byte per handshake.
// A load on the same edge as the final byte's handshake starts the next
// value without a bubble.
module varint_emitter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [63:0] load_value,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  output logic        last
);

  logic [63:0] rem_q, rem_d;
  logic        active_q, active_d;
  logic        more;

  assign more      = |rem_q[63:7];
  assign out_valid = active_q;
  assign last      = active_q && !more;
  assign out_byte  = active_q ? {more, rem_q[6:0]} : 8'h00;

  // Shift out 7 bits per accepted byte; a load overrides the shift.
  always_comb begin
    rem_d    = rem_q;
    active_d = active_q;
    if (active_q && out_ready) begin
      rem_d = rem_q >> 7;
      if (!more) active_d = 1'b0;
    end
    if (load) begin
      rem_d    = load_value;
      active_d = 1'b1;
    end
  end

  // Remaining-value and activity registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_q    <= '0;
      active_q <= 1'b0;
    end else begin
      rem_q    <= rem_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/field_serializer.sv
// Serializes one field-table entry into its protobuf wire encoding:
// fetch the field value from object memory, then emit tag and payload.
module field_serializer
  import field_serializer_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  TABLE_ENTRY        in_entry,
  input  logic              in_entry_valid,
  input  logic [ADDR_W-1:0] cpp_base_addr,
  output logic              ser_ready,
  output logic              ser_done,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [63:0]       mem_resp_data,
  output logic [7:0]        out_byte,
  output logic              out_byte_valid,
  input  logic              out_byte_ready
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_TAG  = 3'd3;
  localparam logic [2:0] S_VAL  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [28:0]       field_id_q, field_id_d;
  FIELD_TYPE         type_q, type_d;
  logic [31:0]       size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [63:0]       payload_q, payload_d;
  logic [2:0]        cnt_q, cnt_d;

  logic        em_load;
  logic [63:0] em_value;
  logic [7:0]  em_byte;
  logic        em_valid, em_last, em_hs;
  logic        is_fixed, fixed_valid;
  logic [2:0]  fixed_last_idx;
  logic        unused_nested;

  // The child-table index is only meaningful to the object buffer.
  assign unused_nested = ^in_entry.nested;

  assign is_fixed       = (type_q == FT_FIXED32) || (type_q == FT_FIXED64);
  assign fixed_last_idx = (type_q == FT_FIXED32) ? 3'd3 : 3'd7;
  assign fixed_valid    = (state_q == S_VAL) && is_fixed;
  assign em_hs          = em_valid && out_byte_ready;

  assign ser_ready      = (state_q == S_IDLE);
  assign ser_done       = (state_q == S_DONE);
  assign mem_req_valid  = (state_q == S_REQ);
  assign mem_req_addr   = addr_q;
  assign out_byte_valid = em_valid || fixed_valid;
  assign out_byte       = fixed_valid ? payload_q[7:0] : em_byte;

  varint_emitter u_varint (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (em_load),
    .load_value (em_value),
    .out_ready  (out_byte_ready),
    .out_byte   (em_byte),
    .out_valid  (em_valid),
    .last       (em_last)
  );

  // Entry sequencing: accept, fetch, tag, payload, completion pulse.
  always_comb begin
    state_d    = state_q;
    field_id_d = field_id_q;
    type_d     = type_q;
    size_d     = size_q;
    addr_d     = addr_q;
    payload_d  = payload_q;
    cnt_d      = cnt_q;
    em_load    = 1'b0;
    em_value   = '0;
    case (state_q)
      S_IDLE: begin
        if (in_entry_valid) begin
          field_id_d = in_entry.field_id;
          type_d     = in_entry.field_type;
          size_d     = in_entry.size;
          addr_d     = cpp_base_addr + ADDR_W'(in_entry.offset);
          if (in_entry.field_id == '0) begin
            state_d = S_DONE;
          end else if (in_entry.field_type == FT_NESTED) begin
            em_load  = 1'b1;
            em_value = tag_value(in_entry.field_id, in_entry.field_type);
            state_d  = S_TAG;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          case (type_q)
            FT_INT32:   payload_d = {{32{mem_resp_data[31]}}, mem_resp_data[31:0]};
            FT_FIXED32: payload_d = {32'd0, mem_resp_data[31:0]};
            default:    payload_d = mem_resp_data;
          endcase
          em_load  = 1'b1;
          em_value = tag_value(field_id_q, type_q);
          state_d  = S_TAG;
        end
      end
      S_TAG: begin
        // Payload starts on the edge that retires the last tag byte.
        if (em_hs && em_last) begin
          state_d = S_VAL;
          cnt_d   = '0;
          if (!is_fixed) begin
            em_load  = 1'b1;
            em_value = (type_q == FT_NESTED) ? 64'(size_q) : payload_q;
          end
        end
      end
      S_VAL: begin
        if (is_fixed) begin
          if (out_byte_ready) begin
            payload_d = payload_q >> 8;
            cnt_d     = cnt_q + 3'd1;
            if (cnt_q == fixed_last_idx) state_d = S_DONE;
          end
        end else if (em_hs && em_last) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      field_id_q <= '0;
      type_q     <= FT_UINT64;
      size_q     <= '0;
      addr_q     <= '0;
      payload_q  <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      field_id_q <= field_id_d;
      type_q     <= type_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      payload_q  <= payload_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule
